// File: rtl/pci_target_ctrl_if.sv
// pci_target_ctrl_if: PCI target bus-side signals (active-low FRAME#/IRDY#/DEVSEL#/STOP#)
// plus the local storage strobes the control stage produces.
`timescale 1ns/1ps
interface pci_target_ctrl_if #(
   parameter int AW = 3
);
   logic          frame;
   logic          irdy;
   logic [31:0]   ad;
   logic [3:0]    cbe;
   logic          devsel;
   logic          storageControl;
   logic          stop;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic          mem_re;
   logic [3:0]    mem_be;

   // slave: the target control stage; master: whoever drives the PCI bus side.
   modport slave (
      input  frame, irdy, ad, cbe,
      output devsel, storageControl, stop, mem_addr, mem_we, mem_re, mem_be
   );
   modport master (
      output frame, irdy, ad, cbe,
      input  devsel, storageControl, stop, mem_addr, mem_we, mem_re, mem_be
   );
endinterface

// File: rtl/pci_target_ctrl.sv
// pci_target_ctrl: PCI memory target decode/claim/burst control feeding the TRDY# generator.
// Optional macro PCI_TGT_WAIT_EN inserts one TRDY#-high WAIT cycle between burst data phases.
`timescale 1ns/1ps
module pci_target_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int          MEM_WORDS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   pci_target_ctrl_if.slave        bus,
   output logic [2:0]              o_dbg_state
);
   localparam int            AW         = $clog2(MEM_WORDS);
   localparam logic [AW-1:0] LAST_WORD  = AW'(MEM_WORDS - 1);
   localparam logic [3:0]    CMD_MEM_RD = 4'b0110;
   localparam logic [3:0]    CMD_MEM_WR = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_TURN    = 3'd1,
      S_DATA    = 3'd2,
      S_WAIT    = 3'd3,
      S_BACKOFF = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_devsel;
   logic          r_sc;
   logic          r_stop;
   logic          r_write;
   logic          r_ignore;
   logic [AW-1:0] r_mem_addr;
   logic [AW-1:0] w_mem_addr_nxt;
   logic          w_write_nxt;
   logic          w_ignore_nxt;
   logic          w_addr_phase;
   logic          w_hit;
   logic          w_xfer;
   logic          w_unused_ad;

   assign w_unused_ad  = ^bus.ad[1:0];
   // r_ignore marks a transaction we did not claim; it lasts until the bus goes idle.
   assign w_addr_phase = (r_state == S_IDLE) & ~bus.frame & ~r_ignore;
   assign w_hit        = (bus.ad[31:5] == BASE_ADDR[31:5]) &
                         ((bus.cbe == CMD_MEM_RD) | (bus.cbe == CMD_MEM_WR));
   assign w_xfer       = (r_state == S_DATA) & ~bus.irdy & r_sc;

   always_comb begin
      w_state_nxt    = r_state;
      w_mem_addr_nxt = r_mem_addr;
      w_write_nxt    = r_write;
      w_ignore_nxt   = r_ignore;
      if (r_ignore && bus.frame && bus.irdy) begin
         w_ignore_nxt = 1'b0;
      end
      case (r_state)
         S_IDLE: begin
            if (w_addr_phase) begin
               w_mem_addr_nxt = bus.ad[AW+1:2];
               w_write_nxt    = bus.cbe[0];
               if (!w_hit) begin
                  w_ignore_nxt = 1'b1;
               end else if (bus.cbe[0]) begin
                  w_state_nxt = S_DATA;
               end else begin
                  w_state_nxt = S_TURN;
               end
            end
         end
         S_TURN: w_state_nxt = S_DATA;
         S_DATA: begin
            if (w_xfer) begin
               if (bus.frame) begin
                  w_state_nxt = S_IDLE;
               end else if (r_mem_addr == LAST_WORD) begin
                  w_state_nxt = S_BACKOFF;
               end else begin
                  w_mem_addr_nxt = r_mem_addr + AW'(1);
`ifdef PCI_TGT_WAIT_EN
                  w_state_nxt    = S_WAIT;
`else
                  w_state_nxt    = S_DATA;
`endif
               end
            end
         end
         S_WAIT:    w_state_nxt = S_DATA;
         S_BACKOFF: begin
            if (bus.frame) begin
               w_state_nxt = S_IDLE;
            end
         end
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Bus-facing controls are registered from the next state so they change on the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_devsel   <= 1'b1;
         r_sc       <= 1'b0;
         r_stop     <= 1'b1;
         r_write    <= 1'b0;
         r_ignore   <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_devsel   <= (w_state_nxt == S_IDLE);
         r_sc       <= (w_state_nxt == S_DATA);
         r_stop     <= (w_state_nxt != S_BACKOFF);
         r_write    <= w_write_nxt;
         r_ignore   <= w_ignore_nxt;
         r_mem_addr <= w_mem_addr_nxt;
      end
   end

   assign bus.devsel         = r_devsel;
   assign bus.storageControl = r_sc;
   assign bus.stop           = r_stop;
   assign bus.mem_addr       = r_mem_addr;
   assign bus.mem_we         = w_xfer & r_write;
   assign bus.mem_re         = ((r_state == S_DATA) | (r_state == S_WAIT)) & ~r_write;
   assign bus.mem_be         = (r_state == S_DATA) ? ~bus.cbe : 4'b0000;
   assign o_dbg_state        = r_state;
endmodule
